// File: rtl/sseg_scan_mux_if.sv
// Bundle between display-data logic and the seven-segment scan driver.
//   master : display-data side; drives patterns/enables/brightness and sees
//            the scanned pin drive.
//   slave  : the scan driver (sseg_scan_mux).
// Signals:
//   seg_in     [NUM_DIGITS*SEG_W] digit i pattern at [i*SEG_W +: SEG_W], active-low
//   digit_en   [NUM_DIGITS]       1 = digit shown
//   blink_en   [NUM_DIGITS]       1 = digit blanked during blink-off phase
//   brightness [BRIGHT_W]         PWM duty code, 0 = dark, all-ones = full on
//   an         [NUM_DIGITS]       anode enables, one-hot active-low
//   sseg       [SEG_W]            segment drive, active-low
//   digit_idx  [clog2(NUM_DIGITS)] slot index aligned with an/sseg
//   frame_tick                    pulse on the first output cycle of slot 0
interface sseg_scan_mux_if #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned SEG_W      = 8,
   parameter int unsigned BRIGHT_W   = 4
);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

   logic [NUM_DIGITS*SEG_W-1:0] seg_in;
   logic [NUM_DIGITS-1:0]       digit_en;
   logic [NUM_DIGITS-1:0]       blink_en;
   logic [BRIGHT_W-1:0]         brightness;
   logic [NUM_DIGITS-1:0]       an;
   logic [SEG_W-1:0]            sseg;
   logic [IDX_W-1:0]            digit_idx;
   logic                        frame_tick;

   modport master (
      output seg_in, digit_en, blink_en, brightness,
      input  an, sseg, digit_idx, frame_tick
   );

   modport slave (
      input  seg_in, digit_en, blink_en, brightness,
      output an, sseg, digit_idx, frame_tick
   );
endinterface

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with per-digit blanking and
// blink, PWM brightness and anode dead-time at the start of each slot.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   bus   slave modport of sseg_scan_mux_if (data inputs, registered an/sseg/
//         digit_idx/frame_tick outputs)
// Each digit slot lasts 2^DIV_W cycles; outputs are registered one cycle
// behind the counter state.
module sseg_scan_mux #(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned SEG_W        = 8,
   parameter int unsigned DIV_W        = 16,
   parameter int unsigned BRIGHT_W     = 4,
   parameter int unsigned BLINK_FRAMES = 64,
   parameter int unsigned DEAD_CYC     = 0
) (
   input  logic            clk,
   input  logic            reset,
   sseg_scan_mux_if.slave  bus
);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIV_W-1:0]      pre;
   logic [IDX_W-1:0]      idx;
   logic [FC_W-1:0]       frame_cnt;
   logic                  blink_ph;

   logic [NUM_DIGITS-1:0] an_q;
   logic [SEG_W-1:0]      sseg_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  tick_q;

   logic [SEG_W-1:0]      seg_sel;
   logic [NUM_DIGITS-1:0] an_sel;
   logic                  en_sel;
   logic                  blk_sel;
   logic [BRIGHT_W-1:0]   duty;
   logic                  pwm_on;
   logic                  dead_ok;
   logic                  lit;
   logic                  slot_end;
   logic                  last_digit;
   logic                  last_frame;

   assign slot_end   = (pre == '1);
   assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
   assign last_frame = (frame_cnt == FC_W'(BLINK_FRAMES - 1));

   // Per-digit select by compare rather than shift/multiply so that a
   // non-power-of-2 digit count never indexes past the vectors.
   always_comb begin
      seg_sel = '1;
      an_sel  = '1;
      en_sel  = 1'b0;
      blk_sel = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            seg_sel   = bus.seg_in[i*SEG_W +: SEG_W];
            an_sel[i] = 1'b0;
            en_sel    = bus.digit_en[i];
            blk_sel   = bus.blink_en[i];
         end
      end
   end

   // Duty compares the top prescaler bits; all-ones forces full on so the
   // brightest code is not one step short of 100 %.
   assign duty   = pre[DIV_W-1 -: BRIGHT_W];
   assign pwm_on = (bus.brightness == '1) || (duty < bus.brightness);

   if (DEAD_CYC == 0) begin : g_no_dead
      assign dead_ok = 1'b1;
   end else begin : g_dead
      assign dead_ok = (pre >= DIV_W'(DEAD_CYC));
   end

   assign lit = en_sel & ~(blk_sel & blink_ph) & dead_ok & pwm_on;

   always_ff @(posedge clk) begin
      if (reset) begin
         pre       <= '0;
         idx       <= '0;
         frame_cnt <= '0;
         blink_ph  <= 1'b0;
         an_q      <= '1;
         sseg_q    <= '1;
         idx_q     <= '0;
         tick_q    <= 1'b0;
      end else begin
         pre <= pre + 1'b1;
         if (slot_end) begin
            if (last_digit) begin
               idx <= '0;
               if (last_frame) begin
                  frame_cnt <= '0;
                  blink_ph  <= ~blink_ph;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end else begin
               idx <= idx + 1'b1;
            end
         end
         an_q   <= lit ? an_sel : '1;
         sseg_q <= lit ? seg_sel : '1;
         idx_q  <= idx;
         tick_q <= (idx == '0) && (pre == '0);
      end
   end

   assign bus.an         = an_q;
   assign bus.sseg       = sseg_q;
   assign bus.digit_idx  = idx_q;
   assign bus.frame_tick = tick_q;
endmodule
